// File: rtl/seq_alu.sv
// seq_alu: handshaked EXE-stage execution unit.
//   Single-cycle ops (ADD/SUB/logic/shifts) complete one cycle after accept.
//   Multiply and divide are iterative: WIDTH CALC cycles, one FIX cycle, then
//   the result is presented with a one-cycle out_valid pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   flush      in   synchronous abort, returns the unit to IDLE
//   in_valid   in   operation offered
//   in_ready   out  unit can accept (IDLE only)
//   EXE_CMD    in   4-bit opcode
//   Val1/Val2  in   operands
//   out_valid  out  result pulse
//   res_lo     out  ALU result / product low / quotient
//   res_hi     out  0 / product high / remainder
//   illegal_op out  pulses with out_valid for undefined opcodes
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready; single-cycle ops complete here
// CALC  | one partial product / quotient bit per cycle
// FIX   | sign correction, divide-by-zero override, result load
`timescale 1ns/1ps
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] Val1,
    input  logic [WIDTH-1:0] Val2,
    output logic             out_valid,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             illegal_op
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_NOR   = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SLA   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_SRL   = 4'd10;
    localparam logic [3:0] OP_MULT  = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;
    localparam logic [3:0] OP_DIVU  = 4'd14;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           r_state;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi;      // partial product high / running remainder
    logic [WIDTH-1:0] r_lo;      // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] r_b;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_a;       // raw Val1, needed for divide-by-zero
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;
    logic             r_out_valid;
    logic             r_illegal;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;

    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_alu;
    logic               w_illegal;
    logic               w_is_multi;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_out_valid;
    assign illegal_op = r_illegal;
    assign res_lo     = r_res_lo;
    assign res_hi     = r_res_hi;

    assign w_shamt = Val2[SHW-1:0];

    always_comb begin
        w_alu     = '0;
        w_illegal = 1'b0;
        case (EXE_CMD)
            OP_ADD:  w_alu = Val1 + Val2;
            OP_SUB:  w_alu = Val1 - Val2;
            OP_AND:  w_alu = Val1 & Val2;
            OP_OR:   w_alu = Val1 | Val2;
            OP_NOR:  w_alu = ~(Val1 | Val2);
            OP_XOR:  w_alu = Val1 ^ Val2;
            OP_SLA:  w_alu = Val1 << w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(Val1) >>> w_shamt);
            OP_SRL:  w_alu = Val1 >> w_shamt;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_is_multi = (EXE_CMD == OP_MULT) || (EXE_CMD == OP_MULTU) ||
                        (EXE_CMD == OP_DIV)  || (EXE_CMD == OP_DIVU);
    assign w_signed   = (EXE_CMD == OP_MULT) || (EXE_CMD == OP_DIV);
    assign w_a_neg    = w_signed & Val1[WIDTH-1];
    assign w_b_neg    = w_signed & Val2[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -Val1 : Val1;
    assign w_b_mag    = w_b_neg ? -Val2 : Val2;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the {carry, hi, lo} chain right by one.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Restoring step: the remainder is always below the divisor, so the
    // shifted value fits in WIDTH+1 bits and the kept result in WIDTH bits.
    assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_trial  = w_rem_sh - {1'b0, r_b};

    assign w_prod_neg = -{r_hi, r_lo};
    // Most-negative / -1 needs no special case: the magnitude quotient is
    // 2^(WIDTH-1), both signs negative so it is left as is, remainder 0.
    assign w_q_fix = r_neg_q ? -r_lo : r_lo;
    assign w_r_fix = r_neg_r ? -r_hi : r_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_b         <= '0;
            r_a         <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_res_lo    <= '0;
            r_res_hi    <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid) begin
                            if (w_is_multi) begin
                                r_state  <= S_CALC;
                                r_cnt    <= '0;
                                r_hi     <= '0;
                                r_lo     <= w_a_mag;
                                r_b      <= w_b_mag;
                                r_a      <= Val1;
                                r_is_div <= (EXE_CMD == OP_DIV) || (EXE_CMD == OP_DIVU);
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_dbz    <= (Val2 == '0);
                            end else begin
                                r_res_lo    <= w_alu;
                                r_res_hi    <= '0;
                                r_out_valid <= 1'b1;
                                r_illegal   <= w_illegal;
                            end
                        end
                    end
                    S_CALC: begin
                        if (r_is_div) begin
                            r_hi <= w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], w_ge};
                        end else begin
                            r_hi <= w_sum[WIDTH:1];
                            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
                        end
                        if (r_cnt == SHW'(WIDTH-1)) begin
                            r_state <= S_FIX;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + SHW'(1);
                        end
                    end
                    S_FIX: begin
                        if (!r_is_div) begin
                            {r_res_hi, r_res_lo} <= r_neg_q ? w_prod_neg : {r_hi, r_lo};
                        end else if (r_dbz) begin
                            r_res_lo <= '1;
                            r_res_hi <= r_a;
                        end else begin
                            r_res_lo <= w_q_fix;
                            r_res_hi <= w_r_fix;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  EXE_CMD;
    logic [31:0] Val1;
    logic [31:0] Val2;
    logic        out_valid;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        illegal_op;

    int n_cmp = 0;
    int n_bad = 0;
    int ov_cnt = 0;
    int ov_base;

    seq_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .EXE_CMD    (EXE_CMD),
        .Val1       (Val1),
        .Val2       (Val2),
        .out_valid  (out_valid),
        .res_lo     (res_lo),
        .res_hi     (res_hi),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid) ov_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers a multi-cycle op at the next edge, scrambles the inputs while
    // busy, and checks latency, busy length and the result.
    task automatic run_multi(input string tag, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int lat;
        int low;
        bit seen;
        EXE_CMD = op; Val1 = a; Val2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; EXE_CMD = 4'd0; Val1 = 32'hDEAD_BEEF; Val2 = 32'h1234_5678;
        lat = 0; low = 0; seen = 1'b0;
        for (int j = 0; j < 100 && !seen; j++) begin
            if (!in_ready) low++;
            if (out_valid) begin
                seen = 1'b1;
                lat  = j + 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'd34);
        chk({tag, " busy"}, 64'(low), 64'd33);
        chk({tag, " lo"}, {32'h0, res_lo}, {32'h0, exp_lo});
        chk({tag, " hi"}, {32'h0, res_hi}, {32'h0, exp_hi});
        chk({tag, " illegal"}, {63'h0, illegal_op}, 64'd0);
    endtask

    logic [3:0]  t_op  [0:13] = '{4'd0, 4'd2, 4'd9, 4'd10, 4'd8, 4'd3, 4'd4,
                                   4'd5, 4'd6, 4'd7, 4'd15, 4'd1, 4'd0, 4'd2};
    logic [31:0] t_a   [0:13] = '{32'd7, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1,
                                   32'h1111_1111, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                   32'hF0F0_F0F0, 32'hAAAA_5555, 32'd1, 32'd5,
                                   32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_b   [0:13] = '{32'hFFFF_FFFD, 32'd9, 32'd36, 32'd36, 32'd33,
                                   32'h2222_2222, 32'hFF00_FF00, 32'h0F0F_0F0F,
                                   32'h0F00_0000, 32'hFFFF_0000, 32'd2, 32'd6,
                                   32'd1, 32'd1};
    logic [31:0] t_exp [0:13] = '{32'd4, 32'hFFFF_FFFC, 32'hF800_0000, 32'h0800_0000,
                                   32'd2, 32'd0, 32'hF000_F000, 32'hFFFF_FFFF,
                                   32'h000F_0F0F, 32'h5555_5555, 32'd0, 32'd0,
                                   32'd0, 32'hFFFF_FFFF};
    logic        t_ill [0:13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        EXE_CMD = 4'd0; Val1 = 32'd0; Val2 = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {63'h0, in_ready}, 64'd1);
        chk("reset out_valid", {63'h0, out_valid}, 64'd0);
        chk("reset illegal", {63'h0, illegal_op}, 64'd0);
        chk("reset res_lo", {32'h0, res_lo}, 64'd0);
        chk("reset res_hi", {32'h0, res_hi}, 64'd0);

        @(negedge clk); rst = 1'b1;

        // Back-to-back single-cycle ops, one accepted per edge.
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            EXE_CMD = t_op[i]; Val1 = t_a[i]; Val2 = t_b[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("op%0d valid", i), {63'h0, out_valid}, 64'd1);
            chk($sformatf("op%0d ready", i), {63'h0, in_ready}, 64'd1);
            chk($sformatf("op%0d lo", i), {32'h0, res_lo}, {32'h0, t_exp[i]});
            chk($sformatf("op%0d hi", i), {32'h0, res_hi}, 64'd0);
            chk($sformatf("op%0d illegal", i), {63'h0, illegal_op}, {63'h0, t_ill[i]});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle out_valid", {63'h0, out_valid}, 64'd0);
        chk("idle illegal", {63'h0, illegal_op}, 64'd0);
        chk("hold res_lo", {32'h0, res_lo}, 64'hFFFF_FFFF);

        run_multi("mult -3*5",   4'd11, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFF1, 32'hFFFF_FFFF);
        run_multi("multu",       4'd12, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE, 32'd1);
        run_multi("mult -4*-6",  4'd11, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'd24,       32'd0);
        run_multi("divu 100/7",  4'd14, 32'd100,       32'd7,        32'd14,        32'd2);
        run_multi("div -7/2",    4'd13, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_multi("div 7/-2",    4'd13, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_multi("div ovf",     4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_multi("divu 9/0",    4'd14, 32'd9,         32'd0,        32'hFFFF_FFFF, 32'd9);
        run_multi("div -9/0",    4'd13, 32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF7);

        // Flush on the 10th CALC cycle with an ADD offered on the same edge.
        EXE_CMD = 4'd13; Val1 = 32'd100; Val2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ov_base = ov_cnt;
        repeat (9) @(posedge clk);
        #1;
        chk("pre-flush busy", {63'h0, in_ready}, 64'd0);
        flush = 1'b1; in_valid = 1'b1; EXE_CMD = 4'd0; Val1 = 32'd50; Val2 = 32'd50;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush ready", {63'h0, in_ready}, 64'd1);
        chk("flush no valid", {63'h0, out_valid}, 64'd0);
        chk("flush hold lo", {32'h0, res_lo}, 64'hFFFF_FFFF);
        EXE_CMD = 4'd0; Val1 = 32'd1; Val2 = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post-flush valid", {63'h0, out_valid}, 64'd1);
        chk("post-flush lo", {32'h0, res_lo}, 64'd2);
        chk("post-flush hi", {32'h0, res_hi}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush pulse count", 64'(ov_cnt - ov_base), 64'd1);

        // Reset asserted mid-MULT for two cycles.
        EXE_CMD = 4'd11; Val1 = 32'd3; Val2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst ready", {63'h0, in_ready}, 64'd1);
        chk("midrst lo", {32'h0, res_lo}, 64'd0);
        chk("midrst hi", {32'h0, res_hi}, 64'd0);
        chk("midrst valid", {63'h0, out_valid}, 64'd0);
        chk("midrst illegal", {63'h0, illegal_op}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        ov_base = ov_cnt;
        @(posedge clk); #1;
        chk("release ready", {63'h0, in_ready}, 64'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("no stale valid", 64'(ov_cnt - ov_base), 64'd0);

        EXE_CMD = 4'd2; Val1 = 32'd0; Val2 = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("after rst valid", {63'h0, out_valid}, 64'd1);
        chk("after rst lo", {32'h0, res_lo}, 64'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
